// File: rtl/conv_pass_sequencer.sv
// conv_pass_sequencer: runtime-configured pixel/loop/filter pass sequencer with stall and done pulse.
module conv_pass_sequencer #(
  parameter int ADDRESS_DATAWIDTH = 13,
  parameter int SIZE_DATAWIDTH = 7,
  parameter int LOOP_DATAWIDTH = 3,
  parameter int FILTER_DATAWIDTH = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [SIZE_DATAWIDTH-1:0] cfg_out_size,
  input  logic [LOOP_DATAWIDTH-1:0] cfg_loop_max,
  input  logic [FILTER_DATAWIDTH-1:0] cfg_filter_max,
  input  logic stall,
  output logic busy,
  output logic [ADDRESS_DATAWIDTH-1:0] out_address,
  output logic [LOOP_DATAWIDTH-1:0] current_loop,
  output logic [FILTER_DATAWIDTH-1:0] current_filter,
  output logic first_loop,
  output logic last_loop,
  output logic change,
  output logic done
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state;
  logic [ADDRESS_DATAWIDTH-1:0] pass_end, cfg_end, size_ext, next_address;
  logic [LOOP_DATAWIDTH-1:0] loop_max, next_loop;
  logic [FILTER_DATAWIDTH-1:0] filter_max;
  always_comb begin
    size_ext = ADDRESS_DATAWIDTH'(cfg_out_size);
    cfg_end = size_ext * size_ext - ADDRESS_DATAWIDTH'(1);
    next_address = out_address + ADDRESS_DATAWIDTH'(1);
    next_loop = current_loop + LOOP_DATAWIDTH'(1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pass_end <= '0;
      loop_max <= '0;
      filter_max <= '0;
      busy <= 1'b0;
      out_address <= '0;
      current_loop <= '0;
      current_filter <= '0;
      first_loop <= 1'b0;
      last_loop <= 1'b0;
      change <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && cfg_out_size != '0) begin
            state <= RUN;
            pass_end <= cfg_end;
            loop_max <= cfg_loop_max;
            filter_max <= cfg_filter_max;
            busy <= 1'b1;
            out_address <= '0;
            current_loop <= '0;
            current_filter <= '0;
            first_loop <= 1'b1;
            last_loop <= cfg_loop_max == '0;
            change <= cfg_end == '0;
          end
        end
        RUN: begin
          if (!stall) begin
            if (out_address != pass_end) begin
              out_address <= next_address;
              change <= next_address == pass_end;
            end else if (current_loop != loop_max) begin
              out_address <= '0;
              change <= pass_end == '0;
              current_loop <= next_loop;
              first_loop <= 1'b0;
              last_loop <= next_loop == loop_max;
            end else if (current_filter != filter_max) begin
              out_address <= '0;
              change <= pass_end == '0;
              current_loop <= '0;
              current_filter <= current_filter + FILTER_DATAWIDTH'(1);
              first_loop <= 1'b1;
              last_loop <= loop_max == '0;
            end else begin
              // final pixel of the final pass: clear everything and raise done for FINISH
              state <= FINISH;
              busy <= 1'b0;
              done <= 1'b1;
              out_address <= '0;
              current_loop <= '0;
              current_filter <= '0;
              first_loop <= 1'b0;
              last_loop <= 1'b0;
              change <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_conv_pass_sequencer.sv
// tb_conv_pass_sequencer: randomized layers checked against a nested-loop reference of the pass order.
module tb_conv_pass_sequencer;
  localparam int AW = 13, SW = 7, LW = 3, FW = 5;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stall = 1'b0;
  logic [SW-1:0] cfg_out_size = '0;
  logic [LW-1:0] cfg_loop_max = '0;
  logic [FW-1:0] cfg_filter_max = '0;
  logic busy, first_loop, last_loop, change, done;
  logic [AW-1:0] out_address;
  logic [LW-1:0] current_loop;
  logic [FW-1:0] current_filter;
  int checks = 0, errors = 0;
  typedef struct {int a; int l; int f; int lm; int last_a;} step_t;
  step_t exp_q[$];

  always #5 clk = ~clk;

  conv_pass_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .cfg_out_size(cfg_out_size),
    .cfg_loop_max(cfg_loop_max), .cfg_filter_max(cfg_filter_max), .stall(stall),
    .busy(busy), .out_address(out_address), .current_loop(current_loop),
    .current_filter(current_filter), .first_loop(first_loop), .last_loop(last_loop),
    .change(change), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_idle(input string tag, input logic exp_done);
    check({tag, ".done"}, 32'(done), 32'(exp_done));
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".addr"}, 32'(out_address), 0);
    check({tag, ".loop"}, 32'(current_loop), 0);
    check({tag, ".filter"}, 32'(current_filter), 0);
    check({tag, ".first"}, 32'(first_loop), 0);
    check({tag, ".last"}, 32'(last_loop), 0);
    check({tag, ".change"}, 32'(change), 0);
  endtask

  task automatic run_layer(input int n, input int lm, input int fm, input bit rnd, input int abort_at);
    int idx = 0;
    int budget;
    exp_q.delete();
    for (int f = 0; f <= fm; f++)
      for (int l = 0; l <= lm; l++)
        for (int a = 0; a < n * n; a++)
          exp_q.push_back('{a: a, l: l, f: f, lm: lm, last_a: n * n - 1});
    @(negedge clk);
    start = 1'b1;
    cfg_out_size = SW'(n);
    cfg_loop_max = LW'(lm);
    cfg_filter_max = FW'(fm);
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      repeat (3) begin
        expect_idle("zero_size", 1'b0);
        @(negedge clk);
      end
      return;
    end
    budget = exp_q.size() + 8;
    while (idx < exp_q.size()) begin
      if (idx == abort_at) begin
        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        #1;
        expect_idle("abort", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) begin
          @(negedge clk);
          expect_idle("post_abort", 1'b0);
        end
        return;
      end
      check("run.busy", 32'(busy), 1);
      check("run.done", 32'(done), 0);
      check("run.addr", 32'(out_address), exp_q[idx].a);
      check("run.loop", 32'(current_loop), exp_q[idx].l);
      check("run.filter", 32'(current_filter), exp_q[idx].f);
      check("run.first", 32'(first_loop), 32'(exp_q[idx].l == 0));
      check("run.last", 32'(last_loop), 32'(exp_q[idx].l == exp_q[idx].lm));
      check("run.change", 32'(change), 32'(exp_q[idx].a == exp_q[idx].last_a));
      stall = rnd && budget > 0 && ($urandom % 4 == 0);
      start = rnd && ($urandom % 8 == 0);
      cfg_out_size = SW'($urandom);
      cfg_loop_max = LW'($urandom);
      cfg_filter_max = FW'($urandom);
      budget--;
      @(negedge clk);
      if (!stall) idx++;
    end
    stall = 1'b0;
    start = 1'b0;
    expect_idle("finish", 1'b1);
    @(negedge clk);
    expect_idle("idle", 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    expect_idle("reset", 1'b0);
    reset = 1'b0;
    run_layer(2, 1, 1, 1'b0, -1);
    run_layer(3, 0, 0, 1'b1, -1);
    run_layer(2, 2, 0, 1'b0, -1);
    run_layer(2, 0, 0, 1'b0, -1);
    run_layer(1, 0, 3, 1'b0, -1);
    run_layer(1, 2, 2, 1'b1, -1);
    run_layer(0, 1, 1, 1'b0, -1);
    run_layer(82, 0, 0, 1'b1, -1);
    run_layer(3, 1, 1, 1'b1, 5);
    run_layer(3, 0, 1, 1'b1, -1);
    for (int i = 0; i < 12; i++)
      run_layer(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_pass_sequencer.md
Name: conv_pass_sequencer

Overview:
- Parametrised successor to the convolution loop/filter controller.
- Instead of a hard-coded per-layer table keyed by the top-level state, it accepts a runtime layer configuration (output size, input-channel loop count, filter count) on a start handshake.
- It generates the output-pixel address itself, honours a stall input, and sequences loop -> filter passes.
- It drives the systolic-array datapath and the output buffer, and returns a done pulse to the top-level FSM.

Parameters:
- ADDRESS_DATAWIDTH, 13, width of out_address; must satisfy SIZE^2 <= 2^ADDRESS_DATAWIDTH.
- SIZE_DATAWIDTH, 7, width of cfg_out_size.
- LOOP_DATAWIDTH, 3, width of loop counters and cfg_loop_max.
- FILTER_DATAWIDTH, 5, width of filter counters and cfg_filter_max.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a layer; sampled only in IDLE.
- cfg_out_size  in  SIZE_DATAWIDTH  output feature-map side length N; pixels per pass = N*N.
- cfg_loop_max  in  LOOP_DATAWIDTH  last loop index (input-channel groups - 1).
- cfg_filter_max  in  FILTER_DATAWIDTH  last filter index (filters - 1).
- stall  in  1  when 1 in RUN, counters hold.
- busy  out  1  high in RUN.
- out_address  out  ADDRESS_DATAWIDTH  current output-pixel address.
- current_loop  out  LOOP_DATAWIDTH  current loop index.
- current_filter  out  FILTER_DATAWIDTH  current filter index.
- first_loop  out  1  current_loop==0 while busy (datapath loads bias instead of accumulating).
- last_loop  out  1  current_loop==loop_max while busy (datapath applies activation and writes back).
- change  out  1  high while busy and out_address==pass end (parameter-change strobe).
- done  out  1  one-cycle pulse when the layer completes.

Behaviour:
- Reset, async, active-high: state=IDLE. All outputs 0. Latched config cleared.
- IDLE:
  - start=1 with cfg_out_size!=0 -> latch cfg_loop_max, cfg_filter_max and END=N*N-1, computed at ADDRESS_DATAWIDTH width in the start cycle, then go to RUN next cycle.
  - Counters are 0 on RUN entry.
  - start with cfg_out_size==0 is ignored; stays IDLE, no done.
- RUN, per cycle with stall=0 ("advance"):
  - out_address < END: out_address+1.
  - out_address == END: out_address wraps to 0.
    - If current_loop < loop_max: current_loop+1.
    - Else current_loop=0. If current_filter < filter_max: current_filter+1.
    - Else (final pixel of final pass): go to FINISH.
- stall=1: all counters and outputs hold, including change.
- FINISH: done=1 for exactly one cycle, busy=0, counters 0. Next state IDLE.
- All outputs are registered. first_loop, last_loop and change reflect the current counter values in the same cycle, i.e. they are updated in the same edge as the counters.
- Total advances per layer = N*N*(loop_max+1)*(filter_max+1). done is asserted one cycle after the final advance.
- start while busy or in FINISH is ignored. Config inputs are don't-care outside the IDLE start cycle.
- Degenerate N=1: every advance is a pass end; change stays 1 throughout RUN.
- loop_max=0: first_loop and last_loop are both 1 for every pass.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs 0. No done is emitted.

Test Plan:
- Basic layer: N=2, loop_max=1, filter_max=1, stall=0 -> busy for 16 cycles. out_address cycles 0..3 four times. Loop/filter sequence (0,0),(1,0),(0,1),(1,1). change high on address 3. done pulses once at cycle 17 after start.
- Stall: N=3, loop_max=0, filter_max=0, stall=1 on cycles 4-6 -> out_address holds at 3 for those cycles. change is high only at address 8. done appears 3 cycles later than the no-stall case (cycle 13 vs 10).
- Flags: N=2, loop_max=2, filter_max=0 -> first_loop high only in loop 0, last_loop high only in loop 2, never both together. With loop_max=0, both are high for the whole run.
- Edge configs: N=1, loop_max=0, filter_max=3 -> change constant 1, current_filter 0..3 on successive cycles, done after 4 advances. start with N=0 -> no busy, no done.
- Sizing and start rules: N=82 (END=6723) -> out_address reaches 6723 and wraps to 0. A start pulsed mid-run is ignored; the config change has no effect.
- Reset mid-operation: reset asserted at address 5 -> all outputs 0 immediately, no done. A new start afterwards runs a clean layer from address 0.
